ff_fifo_with_level: RTL
=======================

FF_FIFO_WITH_LEVEL -- requirements
Module: ff_fifo_with_level

Interface
REQ-001 SHALL have parameter width, default 8, data bits per entry.
REQ-002 SHALL have parameter depth, default 5, number of entries; any integer >= 2, not limited to powers of two.
REQ-003 SHALL have parameter allow_push_when_full_with_pop, default 1; 1 = push accepted when full if pop is asserted in the same cycle.
REQ-004 SHALL have parameter almost_full_level, default depth - 1, level at or above which almost_full asserts.
REQ-005 SHALL have parameter almost_empty_level, default 1, level at or below which almost_empty asserts.
REQ-006 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port push  input  1  write request.
REQ-009 SHALL have port pop  input  1  read request.
REQ-010 SHALL have port write_data  input  width  data written on accepted push.
REQ-011 SHALL have port clear_errors  input  1  clears sticky error flags.
REQ-012 SHALL have port read_data  output  width  head entry, show-ahead.
REQ-013 SHALL have port empty  output  1  level == 0.
REQ-014 SHALL have port full  output  1  level == depth.
REQ-015 SHALL have port almost_empty  output  1  level <= almost_empty_level.
REQ-016 SHALL have port almost_full  output  1  level >= almost_full_level.
REQ-017 SHALL have port level  output  $clog2(depth+1)  current entry count.
REQ-018 SHALL have port overflow  output  1  sticky: a push was rejected.
REQ-019 SHALL have port underflow  output  1  sticky: a pop was rejected.

Function
REQ-020 SHALL store entries in a flip-flop array indexed by write and read pointers; each pointer increments on its accepted operation and wraps from depth-1 to 0.
REQ-021 SHALL accept pop when not empty; pop on empty ignored, no bypass of same-cycle push.
REQ-022 SHALL accept push when not full; when full, accept push only if allow_push_when_full_with_pop = 1 and pop is asserted.
REQ-023 SHALL update level next cycle: +1 on push only, -1 on pop only, unchanged on both or neither accepted.
REQ-024 SHALL drive read_data combinationally from the entry at the read pointer; zero latency from pop acceptance to next head visible after the edge; value undefined when empty and not checked.
REQ-025 SHALL derive empty, full, almost_empty, almost_full combinationally from level registers only (no input-to-output combinational paths).
REQ-026 SHALL set overflow on a cycle with push asserted and push not accepted; set underflow on pop asserted while empty; both remain set until cleared.
REQ-027 SHALL clear overflow/underflow on clear_errors; a same-cycle new error SHALL win (flag stays set).
REQ-028 SHALL leave storage contents unchanged on rejected pushes and pointers unchanged on rejected operations.

Reset
REQ-029 SHALL on rst set both pointers 0, level 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0; storage array not reset.
REQ-030 SHALL give rst priority over push, pop and clear_errors; reset mid-operation discards all contents within one cycle.

Verification (width 8, depth 5, almost_full_level 4, almost_empty_level 1)
REQ-031 Fill and drain: push 0x00,0x11,0x22,0x33,0x44 -> full=1, level=5, almost_full from level 4; then pop 5 -> read_data 0x00..0x44 in order, empty=1.
REQ-032 Push on full without pop: push 0x55 at level 5 -> level stays 5, overflow=1, next pops return 0x00..0x44; clear_errors -> overflow=0.
REQ-033 Push+pop on full with allow=1: write 0x99 -> level stays 5, head advances, 0x99 emerges fifth; with allow=0 -> push rejected, overflow=1, level 4.
REQ-034 Pop on empty with simultaneous push 0x77: level 1, underflow=1, read_data=0x77 next cycle.
REQ-035 Back-to-back: fill to 2, then push+pop every cycle for 25 cycles -> level constant 2, data in order across pointer wraps.
REQ-036 Reset mid-stream at level 3 with overflow set -> next cycle level 0, empty=1, overflow=0; random 100-cycle push/pop run checked against a reference queue model.

Source files
------------

// File: rtl/ff_fifo_with_level.sv
// Flip-flop FIFO with any depth >= 2, show-ahead read data, a level count,
// almost thresholds and sticky overflow/underflow flags.
module ff_fifo_with_level #(
    parameter int width                         = 8,
    parameter int depth                         = 5,
    parameter bit allow_push_when_full_with_pop = 1'b1,
    parameter int almost_full_level             = depth - 1,
    parameter int almost_empty_level            = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [width-1:0]           write_data,
    input  logic                       clear_errors,
    output logic [width-1:0]           read_data,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(depth+1)-1:0] level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = (depth > 2) ? $clog2(depth) : 1;
    localparam int LW = $clog2(depth + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(depth - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(depth);
    localparam logic [LW-1:0] LVL_AF   = LW'(almost_full_level);
    localparam logic [LW-1:0] LVL_AE   = LW'(almost_empty_level);

    logic [width-1:0] mem [depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO is never empty, so a push-with-pop on full always frees a slot.
    always_comb begin
        pop_ok  = pop && (count != '0);
        push_ok = push && ((count != LVL_FULL) || (allow_push_when_full_with_pop && pop));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow  <= (overflow  && !clear_errors) || (push && !push_ok);
            underflow <= (underflow && !clear_errors) || (pop  && !pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            mem[wr_ptr] <= write_data;
    end

    always_comb begin
        read_data    = mem[rd_ptr];
        level        = count;
        empty        = (count == '0);
        full         = (count == LVL_FULL);
        almost_empty = (count <= LVL_AE);
        almost_full  = (count >= LVL_AF);
    end

endmodule
